perf_counter_bank: RTL and testbench

Parametrised performance-counter bank for the pipelined CPU. It counts total cycles plus NUM_EVT single-bit event strobes from the pipeline, such as conditional branches, unconditional jumps, correct branch predictions and load-use stalls. Counting freezes once the core halts. A snapshot/readout path feeds the FPGA display and debug mux without stalling the live counters.

---
 rtl/perf_counter_bank_if.sv | 18 +
 rtl/perf_counter_bank.sv | 68 ++++++
 tb/tb_perf_counter_bank.sv | 114 +++++++++++
 3 files changed

// File: rtl/perf_counter_bank_if.sv
// perf_counter_bank_if: control, event and readout bundle for the performance-counter bank
//   master drives halt/evt/clr/snap/rd_sel and observes rd_data/ovf/lock; slave is the bank.
interface perf_counter_bank_if #(
  parameter int NUM_EVT = 5,
  parameter int CNT_W   = 32,
  parameter int SEL_W   = 4
);
  logic               halt;
  logic [NUM_EVT-1:0] evt;
  logic               clr;
  logic               snap;
  logic [SEL_W-1:0]   rd_sel;
  logic [CNT_W-1:0]   rd_data;
  logic [NUM_EVT:0]   ovf;
  logic               lock;
  modport master (output halt, evt, clr, snap, rd_sel, input rd_data, ovf, lock);
  modport slave  (input halt, evt, clr, snap, rd_sel, output rd_data, ovf, lock);
endinterface

// File: rtl/perf_counter_bank.sv
// perf_counter_bank: cycle + event counters with halt freeze, sticky overflow and snapshot readout
//   clk, rst    : clock, synchronous active-high reset
//   bus.halt    : core halted (level); freezes counting one cycle later
//   bus.evt     : event strobes, bit i counts into counter i+1
//   bus.clr     : clear live counters and overflow flags
//   bus.snap    : copy live counters into shadow registers
//   bus.rd_sel  : shadow select (0 = cycles), rd_data is registered
//   bus.ovf     : sticky overflow flags, bit 0 = cycle counter
//   bus.lock    : counting frozen by halt
module perf_counter_bank #(
  parameter int NUM_EVT = 5,
  parameter int CNT_W   = 32,
  parameter int SAT     = 0,
  parameter int SEL_W   = 4
) (
  input logic clk,
  input logic rst,
  perf_counter_bank_if.slave bus
);
  localparam int N = NUM_EVT + 1;
  typedef enum logic {RUN, FROZEN} state_t;
  state_t state, state_nxt;
  logic inc_en;
  logic [N-1:0] hit, ovf;
  logic [CNT_W-1:0] cnt [N];
  logic [CNT_W-1:0] shd [N];
  logic [CNT_W-1:0] nxt [N];
  logic [CNT_W-1:0] rd_mux, rd_data;
  always_ff @(posedge clk)
    state <= rst ? RUN : state_nxt;
  // The halting cycle itself still counts; while frozen, dropping halt counts immediately.
  always_comb begin
    state_nxt = bus.halt ? FROZEN : RUN;
    inc_en = (state == RUN) || !bus.halt;
  end
  assign hit = {bus.evt, 1'b1} & {N{inc_en}};
  always_comb begin
    for (int i = 0; i < N; i++)
      nxt[i] = (&cnt[i]) ? (SAT != 0 ? cnt[i] : '0) : cnt[i] + CNT_W'(1);
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rst || bus.clr) begin
        cnt[i] <= '0;
        ovf[i] <= 1'b0;
      end else if (hit[i]) begin
        cnt[i] <= nxt[i];
        ovf[i] <= ovf[i] | (&cnt[i]);
      end
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++)
      if (rst) shd[i] <= '0;
      else if (bus.snap) shd[i] <= cnt[i];
  end
  // Selects beyond the last counter fall through to zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < N; i++)
      if (bus.rd_sel == SEL_W'(i)) rd_mux = shd[i];
  end
  always_ff @(posedge clk)
    rd_data <= rst ? '0 : rd_mux;
  assign bus.rd_data = rd_data;
  assign bus.ovf = ovf;
  assign bus.lock = state == FROZEN;
endmodule

// File: tb/tb_perf_counter_bank.sv
// tb_perf_counter_bank: randomized and directed checks of wrap and saturate banks against a reference model
module tb_perf_counter_bank;
  logic clk;
  logic rst;
  int n_chk, n_pass;
  perf_counter_bank_if #(.NUM_EVT(5), .CNT_W(8), .SEL_W(4)) bus0();
  perf_counter_bank_if #(.NUM_EVT(5), .CNT_W(8), .SEL_W(4)) bus1();
  perf_counter_bank #(.NUM_EVT(5), .CNT_W(8), .SAT(0), .SEL_W(4)) dut_wrap (.clk(clk), .rst(rst), .bus(bus0));
  perf_counter_bank #(.NUM_EVT(5), .CNT_W(8), .SAT(1), .SEL_W(4)) dut_sat (.clk(clk), .rst(rst), .bus(bus1));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  int m_cnt [2][6];
  int m_shd [2][6];
  int m_rd [2];
  logic [5:0] m_ovf [2];
  logic m_frozen;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask
  task automatic model(input logic r, h, input logic [4:0] e, input logic c, s, input logic [3:0] sel);
    bit counting;
    counting = !m_frozen || !h;
    for (int m = 0; m < 2; m++) begin
      m_rd[m] = (r || sel > 5) ? 0 : m_shd[m][sel];
      for (int k = 0; k < 6; k++) begin
        if (r) begin
          m_cnt[m][k] = 0;
          m_shd[m][k] = 0;
          m_ovf[m][k] = 1'b0;
        end else begin
          if (s) m_shd[m][k] = m_cnt[m][k];
          if (c) begin
            m_cnt[m][k] = 0;
            m_ovf[m][k] = 1'b0;
          end else if (counting && (k == 0 || e[k-1])) begin
            if (m_cnt[m][k] == 255) begin
              m_ovf[m][k] = 1'b1;
              m_cnt[m][k] = (m == 1) ? 255 : 0;
            end else m_cnt[m][k] = m_cnt[m][k] + 1;
          end
        end
      end
    end
    m_frozen = r ? 1'b0 : h;
  endtask
  task automatic step(input logic r, h, input logic [4:0] e, input logic c, s, input logic [3:0] sel);
    rst = r;
    bus0.halt = h; bus0.evt = e; bus0.clr = c; bus0.snap = s; bus0.rd_sel = sel;
    bus1.halt = h; bus1.evt = e; bus1.clr = c; bus1.snap = s; bus1.rd_sel = sel;
    @(posedge clk);
    model(r, h, e, c, s, sel);
    #1;
    check("rd_wrap", bus0.rd_data, 64'(m_rd[0]));
    check("rd_sat", bus1.rd_data, 64'(m_rd[1]));
    check("ovf_wrap", bus0.ovf, 64'(m_ovf[0]));
    check("ovf_sat", bus1.ovf, 64'(m_ovf[1]));
    check("lock", {bus0.lock, bus1.lock}, {m_frozen, m_frozen});
  endtask
  initial begin
    logic h;
    n_chk = 0;
    n_pass = 0;
    m_frozen = 1'b0;
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    repeat (10) step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    check("plan_cyc10", bus0.rd_data, 10);
    for (int i = 0; i < 12; i++)
      step(0, i >= 5 && i < 10, (i < 4 || i % 2 == 1) ? 5'b00010 : 5'b0, 0, i == 11, 5'(i % 6));
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 4'(i));
    step(0, 0, 0, 1, 0, 0);
    repeat (257) step(0, 0, 5'b00001, 0, 0, 1);
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 1);
    check("plan_wrap", bus0.rd_data, 1);
    check("plan_sat", bus1.rd_data, 255);
    check("plan_ovf_wrap", bus0.ovf[1], 1);
    check("plan_ovf_sat", bus1.ovf[1], 1);
    step(0, 0, 0, 1, 0, 0);
    repeat (20) step(0, 0, 0, 0, 0, 0);
    step(0, 0, 5'b00001, 1, 1, 0);
    check("plan_coll_ovf", bus0.ovf, 0);
    step(0, 0, 0, 0, 1, 0);
    check("plan_coll_shd", bus0.rd_data, 20);
    step(0, 0, 0, 0, 0, 0);
    check("plan_coll_cnt0", bus0.rd_data, 0);
    step(0, 0, 0, 0, 0, 1);
    check("plan_coll_cnt1", bus0.rd_data, 0);
    repeat (30) step(0, 0, 5'($urandom), 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 16; i++) step(0, 0, 0, 0, 0, 4'(i));
    step(0, 0, 0, 0, 0, 15);
    check("plan_sel15", bus0.rd_data, 0);
    repeat (3) step(0, 1, 5'h1f, 0, 0, 0);
    check("plan_frozen", bus0.lock, 1);
    step(1, 1, 5'h1f, 1, 1, 0);
    check("plan_rst_lock", bus0.lock, 0);
    check("plan_rst_ovf", bus1.ovf, 0);
    check("plan_rst_rd", bus1.rd_data, 0);
    repeat (5) step(0, 0, 5'h1f, 0, 0, 0);
    h = 1'b0;
    repeat (3000) begin
      if ($urandom_range(0, 9) == 0) h = ~h;
      step($urandom_range(0, 299) == 0, h, 5'($urandom), $urandom_range(0, 59) == 0,
           $urandom_range(0, 7) == 0, 4'($urandom));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
